ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Round-robin arbiter sharing one generic byte-enable simple dual-port RAM between NUM_REQ requesters
//  (e.g. host offload DMA and RISC-V core data port). At most one command (read or write) is accepted per cycle.
//  Drives the RAM write/read ports directly and routes each read's data back to the requester that issued it.
//  Single clock domain; the RAM's wr_clk and rd_clk are both tied to clk at the instantiation.
// PARAMETERS
//  DATA_WIDTH   32  RAM word width in bits; must be a multiple of 8 (elaboration error otherwise)
//  ADDR_WIDTH   10  RAM word-address width
//  NUM_REQ      2   number of requesters, 2..8
// PORTS
//  clk          in   1                      clock, all logic on rising edge
//  rst          in   1                      asynchronous reset, active-high
//  req_valid    in   NUM_REQ                per-requester command valid
//  req_ready    out  NUM_REQ                per-requester grant; command accepted when valid&ready
//  req_we       in   NUM_REQ                1=write, 0=read
//  req_addr     in   NUM_REQ*ADDR_WIDTH     word address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata    in   NUM_REQ*DATA_WIDTH     write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_be       in   NUM_REQ*DATA_WIDTH/8   byte enables, bit j -> wdata byte j
//  rsp_valid    out  NUM_REQ                one-cycle pulse: read data for requester i on rsp_rdata
//  rsp_rdata    out  DATA_WIDTH             read data, shared by all requesters, qualified by rsp_valid
//  ram_wr_en    out  1                      to RAM wr_en
//  ram_wr_addr  out  ADDR_WIDTH             to RAM wr_addr
//  ram_wr_data  out  DATA_WIDTH             to RAM wr_data
//  ram_wr_be    out  DATA_WIDTH/8           to RAM wr_be
//  ram_rd_addr  out  ADDR_WIDTH             to RAM rd_addr
//  ram_rd_data  in   DATA_WIDTH             from RAM rd_data (registered in RAM, 1-cycle latency)
// BEHAVIOUR
//  - Arbitration combinational: req_ready is one-hot or zero; grant g = first requester with req_valid set,
//    searching from priority pointer ptr upward modulo NUM_REQ. No valid -> req_ready all zero.
//  - Requesters must not make req_valid depend on req_ready; a requester may hold valid with changing fields.
//  - ptr register: reset 0; on any grant ptr <= (g+1) mod NUM_REQ; no grant -> ptr holds.
//  - Write accepted in cycle N: ram_wr_en=1 in N (combinational), wr_addr/data/be = requester g fields;
//    RAM updates at end of N. be=0 write is accepted, consumes the slot, changes nothing.
//  - Read accepted in cycle N: ram_rd_addr = req_addr[g] in N; tag {valid,g} registered at end of N;
//    ram_rd_data valid in N+1 and registered into rsp_rdata at end of N+1; rsp_valid[g]=1 in N+2 only.
//    Fixed read latency 2 cycles, one read per cycle sustained, responses strictly in issue order.
//  - No read in N: ram_rd_addr holds last read address (register, reset 0); ram_wr_en=0 when no write granted;
//    ram_wr_addr/data/be are don't-care while ram_wr_en=0.
//  - Read-after-write: write at N, read of same address at N+1 or later returns the new data.
//    Same-cycle RAW impossible (one command per cycle).
//  - No response-side backpressure: requesters must always accept rsp_valid.
//  - rsp_rdata holds its last value when rsp_valid is all zero.
//  - Reset values: req_ready=0 (combinational from valid; no grant while rst=1), rsp_valid=0, rsp_rdata=0,
//    ram_wr_en=0, ram_rd_addr=0, ptr=0, read tag pipeline cleared.
//  - Reset mid-operation: all in-flight read responses are dropped (no rsp_valid after rst deasserts);
//    a write granted in the same cycle rst rises is not issued (ram_wr_en forced 0 during rst).
// TESTING
//  1 rst, single requester 0: write addr 5 data 0xDEADBEEF be 0xF; read addr 5 -> rsp_valid[0] 2 cycles later, rdata 0xDEADBEEF.
//  2 byte enable: write 0x11223344 be 0xF then 0xAABBCCDD be 0x5 to addr 7; read -> 0x11BB33DD.
//  3 both requesters hold valid 8 cycles -> grants alternate 0,1,0,1... starting with 0 after reset; 4 each.
//  4 back-to-back reads: req0 reads 1,2,3 then req1 reads 4 on consecutive cycles -> rsp_valid in issue order
//    at N+2..N+5, ids 0,0,0,1, data matches preloaded words; no gaps.
//  5 write addr 9 = 0x55 in N, req1 read addr 9 in N+1 -> returns 0x55 (RAW ordering).
//  6 issue read, assert rst in N+1 for 1 cycle -> no rsp_valid afterwards; ptr=0, first grant goes to requester 0.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one byte-enable simple dual-port RAM between NUM_REQ requesters.
// Reads return on a fixed two-cycle pipeline, tagged with the issuing requester.
module ram_access_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned NUM_REQ    = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_be,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             ram_wr_en,
   output logic [ADDR_WIDTH-1:0]            ram_wr_addr,
   output logic [DATA_WIDTH-1:0]            ram_wr_data,
   output logic [DATA_WIDTH/8-1:0]          ram_wr_be,
   output logic [ADDR_WIDTH-1:0]            ram_rd_addr,
   input  logic [DATA_WIDTH-1:0]            ram_rd_data
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   generate
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
         $error("ram_access_arbiter: DATA_WIDTH must be a multiple of 8");
      end
      if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
         $error("ram_access_arbiter: NUM_REQ must be in 2..8");
      end
   endgenerate

   logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  tag_vld_q, tag_vld_d;
   logic [PTR_WIDTH-1:0]  tag_id_q, tag_id_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  grant_vld;
   logic [PTR_WIDTH-1:0]  grant_idx;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BE_WIDTH-1:0]   sel_be;
   logic                  wr_fire;
   logic                  rd_fire;

   // Search upward from ptr, wrapping modulo NUM_REQ; no grant is ever given while in reset.
   always_comb begin
      logic [PTR_WIDTH:0]   sum;
      logic [PTR_WIDTH-1:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      sum       = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + (PTR_WIDTH+1)'(k);
         if (sum >= (PTR_WIDTH+1)'(NUM_REQ)) begin
            sum = sum - (PTR_WIDTH+1)'(NUM_REQ);
         end
         cand = sum[PTR_WIDTH-1:0];
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
      if (rst) begin
         grant_vld = 1'b0;
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PTR_WIDTH'(i)) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_be    = req_be[i*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
      wr_fire = grant_vld & sel_we;
      rd_fire = grant_vld & ~sel_we;
   end

   assign ram_wr_en   = wr_fire;
   assign ram_wr_addr = sel_addr;
   assign ram_wr_data = sel_wdata;
   assign ram_wr_be   = sel_be;
   assign ram_rd_addr = rd_fire ? sel_addr : rd_addr_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;

   always_comb begin
      ptr_d = ptr_q;
      if (grant_vld) begin
         ptr_d = (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      rd_addr_d = ram_rd_addr;
      // Stage 1 tags the read issued this cycle; stage 2 captures RAM data one cycle later.
      tag_vld_d = rd_fire;
      tag_id_d  = grant_idx;
      rsp_valid_d = '0;
      if (tag_vld_q) begin
         rsp_valid_d[tag_id_q] = 1'b1;
      end
      rsp_rdata_d = tag_vld_q ? ram_rd_data : rsp_rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         rd_addr_q   <= '0;
         tag_vld_q   <= 1'b0;
         tag_id_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rd_addr_q   <= rd_addr_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized bench for ram_access_arbiter: a behavioural RAM plus a reference model of grants,
// memory contents and the response queue; directed checks cover the key scenarios.
module tb_ram_access_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int NR = 2;
   localparam int BW = DW / 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    req_we;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR*BW-1:0] req_be;
   logic [NR-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             ram_wr_en;
   logic [AW-1:0]    ram_wr_addr;
   logic [DW-1:0]    ram_wr_data;
   logic [BW-1:0]    ram_wr_be;
   logic [AW-1:0]    ram_rd_addr;
   logic [DW-1:0]    ram_rd_data;

   int n_total = 0;
   int n_bad   = 0;

   ram_access_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REQ    (NR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_be      (req_be),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_wr_be   (ram_wr_be),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: byte-enable write port, registered read port.
   logic [DW-1:0] ram_mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_wr_en) begin
         for (int b = 0; b < BW; b++) begin
            if (ram_wr_be[b]) ram_mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
         end
      end
      ram_rd_data <= ram_mem[ram_rd_addr];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, evaluated once per cycle on the falling edge.
   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          exp_q[$];
   logic [DW-1:0] ref_mem [0:31];
   int            ref_ptr = 0;
   logic [AW-1:0] last_rd = '0;
   logic [DW-1:0] last_rdata = '0;
   int            cyc = 0;

   initial begin
      int            g;
      int            idx;
      logic [NR-1:0] exp_v;
      logic [DW-1:0] exp_d;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      logic [BW-1:0] be;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            ref_ptr    = 0;
            last_rd    = '0;
            last_rdata = '0;
            exp_q.delete();
            check_eq("rst_ready", 64'(req_ready), 64'd0);
            check_eq("rst_wr_en", 64'(ram_wr_en), 64'd0);
            check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
            check_eq("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
         end else begin
            exp_v = '0;
            exp_d = last_rdata;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               exp_v[exp_q[0].id] = 1'b1;
               exp_d = exp_q[0].data;
               void'(exp_q.pop_front());
            end
            check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
            last_rdata = exp_d;

            g = -1;
            for (int k = 0; k < NR; k++) begin
               idx = (ref_ptr + k) % NR;
               if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_v = '0;
            if (g >= 0) exp_v[g] = 1'b1;
            check_eq("req_ready", 64'(req_ready), 64'(exp_v));

            if (g >= 0) begin
               a  = req_addr[g*AW +: AW];
               w  = req_wdata[g*DW +: DW];
               be = req_be[g*BW +: BW];
            end else begin
               a = '0; w = '0; be = '0;
            end
            if (g >= 0 && req_we[g]) begin
               check_eq("wr_en", 64'(ram_wr_en), 64'd1);
               check_eq("wr_addr", 64'(ram_wr_addr), 64'(a));
               check_eq("wr_data", 64'(ram_wr_data), 64'(w));
               check_eq("wr_be", 64'(ram_wr_be), 64'(be));
               for (int b = 0; b < BW; b++) begin
                  if (be[b]) ref_mem[a[4:0]][b*8 +: 8] = w[b*8 +: 8];
               end
            end else begin
               check_eq("wr_en_idle", 64'(ram_wr_en), 64'd0);
            end
            if (g >= 0 && !req_we[g]) begin
               check_eq("rd_addr", 64'(ram_rd_addr), 64'(a));
               last_rd = a;
               exp_q.push_back('{due: cyc + 2, id: g, data: ref_mem[a[4:0]]});
            end else begin
               check_eq("rd_addr_hold", 64'(ram_rd_addr), 64'(last_rd));
            end
            if (g >= 0) ref_ptr = (g + 1) % NR;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
   endtask

   // One-cycle command from a single requester, driven just after a rising edge.
   task automatic cmd(input int id, input bit we, input int addr, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
      req_valid            = '0;
      req_valid[id]        = 1'b1;
      req_we[id]           = we;
      req_addr[id*AW +: AW] = addr[AW-1:0];
      req_wdata[id*DW +: DW] = d;
      req_be[id*BW +: BW]  = be;
      step();
      req_valid = '0;
   endtask

   initial begin
      int            cnt0;
      int            cnt1;
      logic [NR-1:0] exp_r;
      logic [AW-1:0] ra;
      rst = 1'b1;
      idle();
      repeat (3) step();
      rst = 1'b0;

      for (int a = 0; a < 32; a++) cmd(a % NR, 1'b1, a, $urandom, 4'hF);

      // Single requester write then read.
      cmd(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
      cmd(0, 1'b0, 5, '0, '0);
      step();
      @(negedge clk);
      check_eq("t1_valid", 64'(rsp_valid), 64'h1);
      check_eq("t1_data", 64'(rsp_rdata), 64'hDEADBEEF);
      step();

      // Partial byte-enable write merges into the existing word.
      cmd(0, 1'b1, 7, 32'h11223344, 4'hF);
      cmd(0, 1'b1, 7, 32'hAABBCCDD, 4'h5);
      cmd(0, 1'b0, 7, '0, '0);
      step();
      @(negedge clk);
      check_eq("t2_valid", 64'(rsp_valid), 64'h1);
      check_eq("t2_data", 64'(rsp_rdata), 64'h11BB33DD);
      step();

      // Both requesters hold valid: grants alternate starting at 0 after reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {10'd1, 10'd0};
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
         check_eq("t3_alt", 64'(req_ready), 64'(exp_r));
         cnt0 += int'(req_ready[0]);
         cnt1 += int'(req_ready[1]);
         step();
      end
      idle();
      check_eq("t3_cnt0", 64'(cnt0), 64'd4);
      check_eq("t3_cnt1", 64'(cnt1), 64'd4);
      repeat (3) step();

      // Back-to-back reads, responses in issue order (checked by the model).
      cmd(0, 1'b0, 1, '0, '0);
      cmd(0, 1'b0, 2, '0, '0);
      cmd(0, 1'b0, 3, '0, '0);
      cmd(1, 1'b0, 4, '0, '0);
      repeat (4) step();

      // Write then read of the same address on the next cycle.
      cmd(0, 1'b1, 9, 32'h55, 4'hF);
      cmd(1, 1'b0, 9, '0, '0);
      step();
      @(negedge clk);
      check_eq("t5_valid", 64'(rsp_valid), 64'h2);
      check_eq("t5_data", 64'(rsp_rdata), 64'h55);
      step();

      // Reset one cycle after a read: the response is dropped and ptr restarts at 0.
      cmd(1, 1'b0, 3, '0, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("t6_no_rsp", 64'(rsp_valid), 64'd0);
         step();
      end
      req_valid = 2'b11;
      @(negedge clk);
      check_eq("t6_first_grant", 64'(req_ready), 64'h1);
      step();
      idle();

      // Random traffic with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         req_valid = NR'($urandom);
         req_we    = NR'($urandom);
         for (int r = 0; r < NR; r++) begin
            ra = AW'($urandom_range(0, 31));
            req_addr[r*AW +: AW]  = ra;
            req_wdata[r*DW +: DW] = $urandom;
            req_be[r*BW +: BW]    = BW'($urandom);
         end
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
